// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the two-requester memory arbiter: size codes, FSM
// state codes, RAM base address and small helpers for beat count / byte mask.
// Latency: n/a (package). Backpressure: n/a (package).
package mem_arbiter_pkg;

    // Access size encodings (bytes = 1 << size)
    localparam logic [1:0] SZ_1B = 2'd0;
    localparam logic [1:0] SZ_2B = 2'd1;
    localparam logic [1:0] SZ_4B = 2'd2;
    localparam logic [1:0] SZ_8B = 2'd3;

    // Arbiter FSM state encodings
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BEAT1 = 2'd1;
    localparam logic [1:0] ST_BEAT2 = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // Byte address where the RAM window starts
    localparam logic [63:0] RAM_BASE = 64'h8000_0000;

    // An access spills into the next 8-byte word when offset + bytes > 8.
    // Evaluated at 4 bits: worst case 7 + 8 = 15 still fits.
    function automatic logic needs_two_beats(input logic [2:0] off,
                                             input logic [1:0] size);
        logic [3:0] sum;
        sum = {1'b0, off} + (4'd1 << size);
        return (sum > 4'd8);
    endfunction

    // One bit per byte lane covered by an access of the given size
    function automatic logic [7:0] size_byte_mask(input logic [1:0] size);
        logic [7:0] m;
        case (size)
            SZ_1B:   m = 8'h01;
            SZ_2B:   m = 8'h03;
            SZ_4B:   m = 8'h0F;
            SZ_8B:   m = 8'hFF;
            default: m = 8'h00;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane aligner shared by read and write paths: shifts write data/mask up
// into a 128-bit two-word window, and extracts/zero-extends read data from it.
// Latency: purely combinational. Backpressure: none (no handshake).
// Ports: off_i/size_i describe the access; wdata_i is LSB-aligned write data;
//        rd_lo_i/rd_hi_i are the two memory words; wr_*_o are the per-beat
//        write data/mask halves; rdata_o is the aligned, masked read result.
module mem_align
    import mem_arbiter_pkg::*;
(
    input  logic [2:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic [63:0] wdata_i,
    input  logic [63:0] rd_lo_i,
    input  logic [63:0] rd_hi_i,
    output logic [63:0] wr_lo_dat_o,
    output logic [63:0] wr_hi_dat_o,
    output logic [63:0] wr_lo_mask_o,
    output logic [63:0] wr_hi_mask_o,
    output logic [63:0] rdata_o
);

    logic [7:0]   byte_mask;
    logic [63:0]  mask64;
    logic [5:0]   sh;
    logic [127:0] wd_sh;
    logic [127:0] wm_sh;

    assign byte_mask = size_byte_mask(size_i);
    assign sh        = {off_i, 3'b000};

    always_comb begin
        mask64 = '0;
        for (int i = 0; i < 8; i++) begin
            mask64[8*i +: 8] = {8{byte_mask[i]}};
        end
    end

    assign wd_sh = {64'h0, wdata_i} << sh;
    assign wm_sh = {64'h0, mask64} << sh;

    assign wr_lo_dat_o  = wd_sh[63:0];
    assign wr_hi_dat_o  = wd_sh[127:64];
    assign wr_lo_mask_o = wm_sh[63:0];
    assign wr_hi_mask_o = wm_sh[127:64];

    // Only the low word of the shifted window is ever needed for reads
    assign rdata_o = 64'({rd_hi_i, rd_lo_i} >> sh) & mask64;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter granting instruction-fetch (if) or load/store (ls)
// access to a 64-bit word memory, splitting unaligned accesses into two beats.
// Latency: ack 2 cycles after the grant-sampling cycle (3 for two beats).
// Backpressure: requester holds req/operands until its 1-cycle ack; no new grant until back in IDLE.
// Ports: clk/rst (sync, active-high); per requester req/addr/size/wen/wdata
//        in, ack/rdata out; memory side addr (word index), ren/rdata, wen/wdata/wmask.
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [63:0] if_addr,
    input  logic [1:0]  if_size,
    input  logic        if_wen,
    input  logic [63:0] if_wdata,
    output logic        if_ack,
    output logic [63:0] if_rdata,
    input  logic        ls_req,
    input  logic [63:0] ls_addr,
    input  logic [1:0]  ls_size,
    input  logic        ls_wen,
    input  logic [63:0] ls_wdata,
    output logic        ls_ack,
    output logic [63:0] ls_rdata,
    output logic [63:0] mem_addr,
    output logic        mem_ren,
    input  logic [63:0] mem_rdata,
    output logic        mem_wen,
    output logic [63:0] mem_wdata,
    output logic [63:0] mem_wmask
);

    logic [1:0]  state_q,   state_d;
    logic        last_ls_q, last_ls_d;   // 1: last grant went to ls
    logic        gnt_ls_q,  gnt_ls_d;    // owner of the current transaction
    logic [63:0] addr_q,    addr_d;
    logic [1:0]  size_q,    size_d;
    logic        wen_q,     wen_d;
    logic [63:0] wdata_q,   wdata_d;
    logic        two_q,     two_d;
    logic [63:0] word1_q,   word1_d;

    logic        pick_ls;
    logic [63:0] sel_addr;

    // Grant selection and FSM next-state
    always_comb begin
        state_d   = state_q;
        last_ls_d = last_ls_q;
        gnt_ls_d  = gnt_ls_q;
        addr_d    = addr_q;
        size_d    = size_q;
        wen_d     = wen_q;
        wdata_d   = wdata_q;
        two_d     = two_q;
        word1_d   = word1_q;
        pick_ls   = 1'b0;
        sel_addr  = if_addr;

        case (state_q)
            ST_IDLE: begin
                if (if_req || ls_req) begin
                    // On a tie the side that did not win last time gets it
                    pick_ls   = ls_req && (!if_req || !last_ls_q);
                    sel_addr  = pick_ls ? ls_addr : if_addr;
                    gnt_ls_d  = pick_ls;
                    last_ls_d = pick_ls;
                    addr_d    = sel_addr;
                    size_d    = pick_ls ? ls_size  : if_size;
                    wen_d     = pick_ls ? ls_wen   : if_wen;
                    wdata_d   = pick_ls ? ls_wdata : if_wdata;
                    two_d     = needs_two_beats(sel_addr[2:0], size_d);
                    state_d   = ST_BEAT1;
                end
            end
            ST_BEAT1: begin
                state_d = two_q ? ST_BEAT2 : ST_RESP;
            end
            ST_BEAT2: begin
                // Memory returns the first-beat word during this cycle
                word1_d = mem_rdata;
                state_d = ST_RESP;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            last_ls_q <= 1'b0;
            gnt_ls_q  <= 1'b0;
            addr_q    <= '0;
            size_q    <= '0;
            wen_q     <= 1'b0;
            wdata_q   <= '0;
            two_q     <= 1'b0;
            word1_q   <= '0;
        end else begin
            state_q   <= state_d;
            last_ls_q <= last_ls_d;
            gnt_ls_q  <= gnt_ls_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            wen_q     <= wen_d;
            wdata_q   <= wdata_d;
            two_q     <= two_d;
            word1_q   <= word1_d;
        end
    end

    // Output decode works only from registered state; rst gates everything so
    // a reset cycle never strobes the memory or a requester.
    logic        live;
    logic        in_b1;
    logic        in_b2;
    logic        in_resp;
    logic [60:0] widx;
    logic [60:0] widx_nxt;

    assign live     = !rst;
    assign in_b1    = (state_q == ST_BEAT1);
    assign in_b2    = (state_q == ST_BEAT2);
    assign in_resp  = (state_q == ST_RESP);
    assign widx     = addr_q[63:3];
    assign widx_nxt = widx + 61'd1;   // wraps modulo 2^61 at the top of memory

    logic [63:0] rd_lo;
    logic [63:0] rd_hi;
    logic [63:0] wr_lo_dat;
    logic [63:0] wr_hi_dat;
    logic [63:0] wr_lo_mask;
    logic [63:0] wr_hi_mask;
    logic [63:0] al_rdata;

    // The final word arrives in the RESP cycle itself, so it feeds the
    // aligner directly; a two-beat read pairs it with the captured word1.
    assign rd_lo = two_q ? word1_q   : mem_rdata;
    assign rd_hi = two_q ? mem_rdata : 64'h0;

    mem_align u_align (
        .off_i        (addr_q[2:0]),
        .size_i       (size_q),
        .wdata_i      (wdata_q),
        .rd_lo_i      (rd_lo),
        .rd_hi_i      (rd_hi),
        .wr_lo_dat_o  (wr_lo_dat),
        .wr_hi_dat_o  (wr_hi_dat),
        .wr_lo_mask_o (wr_lo_mask),
        .wr_hi_mask_o (wr_hi_mask),
        .rdata_o      (al_rdata)
    );

    always_comb begin
        mem_addr  = '0;
        mem_ren   = 1'b0;
        mem_wen   = 1'b0;
        mem_wdata = '0;
        mem_wmask = '0;
        if (live && (in_b1 || in_b2)) begin
            mem_addr = in_b1 ? {3'b000, widx} : {3'b000, widx_nxt};
            mem_ren  = !wen_q;
            mem_wen  = wen_q;
            if (wen_q) begin
                mem_wdata = in_b1 ? wr_lo_dat  : wr_hi_dat;
                mem_wmask = in_b1 ? wr_lo_mask : wr_hi_mask;
            end
        end
    end

    logic [63:0] resp_rdata;
    assign resp_rdata = wen_q ? 64'h0 : al_rdata;

    assign if_ack   = live && in_resp && !gnt_ls_q;
    assign ls_ack   = live && in_resp &&  gnt_ls_q;
    assign if_rdata = if_ack ? resp_rdata : 64'h0;
    assign ls_rdata = ls_ack ? resp_rdata : 64'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed steps with an ack scoreboard
// and a behavioural word memory answering one cycle after mem_ren.
// Latency/backpressure: n/a (testbench).
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [63:0] if_addr = '0;
    logic [1:0]  if_size = '0;
    logic        if_wen = 1'b0;
    logic [63:0] if_wdata = '0;
    logic        if_ack;
    logic [63:0] if_rdata;
    logic        ls_req = 1'b0;
    logic [63:0] ls_addr = '0;
    logic [1:0]  ls_size = '0;
    logic        ls_wen = 1'b0;
    logic [63:0] ls_wdata = '0;
    logic        ls_ack;
    logic [63:0] ls_rdata;
    logic [63:0] mem_addr;
    logic        mem_ren;
    logic [63:0] mem_rdata = '0;
    logic        mem_wen;
    logic [63:0] mem_wdata;
    logic [63:0] mem_wmask;

    mem_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_size   (if_size),
        .if_wen    (if_wen),
        .if_wdata  (if_wdata),
        .if_ack    (if_ack),
        .if_rdata  (if_rdata),
        .ls_req    (ls_req),
        .ls_addr   (ls_addr),
        .ls_size   (ls_size),
        .ls_wen    (ls_wen),
        .ls_wdata  (ls_wdata),
        .ls_ack    (ls_ack),
        .ls_rdata  (ls_rdata),
        .mem_addr  (mem_addr),
        .mem_ren   (mem_ren),
        .mem_rdata (mem_rdata),
        .mem_wen   (mem_wen),
        .mem_wdata (mem_wdata),
        .mem_wmask (mem_wmask)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // 16-word memory indexed by the low bits of the word index
    logic [63:0] tb_mem [16];
    logic        pl_en  = 1'b0;
    logic [3:0]  pl_idx = '0;
    logic [63:0] pl_val = '0;

    always @(posedge clk) begin
        if (pl_en) tb_mem[pl_idx] <= pl_val;
        if (mem_wen)
            tb_mem[mem_addr[3:0]] <= (tb_mem[mem_addr[3:0]] & ~mem_wmask) | (mem_wdata & mem_wmask);
        mem_rdata <= mem_ren ? tb_mem[mem_addr[3:0]] : 64'hBAD0_BAD0_BAD0_BAD0;
    end

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic        ls;
        logic [63:0] rdata;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;

    // Scoreboard: every ack must match the oldest pushed expectation
    always @(negedge clk) begin
        if (if_ack || ls_ack) begin
            if (exp_q.size() == 0) begin
                chk("ack_unexpected", 64'({if_ack, ls_ack}), 64'h0);
            end else begin
                e = exp_q.pop_front();
                chk("ack_port_ls", 64'(ls_ack), 64'(e.ls));
                chk("ack_both", 64'(if_ack & ls_ack), 64'h0);
                chk("ack_rdata", e.ls ? ls_rdata : if_rdata, e.rdata);
                chk("ack_other_rdata", e.ls ? if_rdata : ls_rdata, 64'h0);
                chk("ack_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // Byte-wise reference read from the bench memory
    function automatic logic [63:0] model_read(input logic [63:0] a, input logic [1:0] sz);
        logic [127:0] cat;
        logic [60:0]  wi;
        logic [60:0]  wn;
        logic [63:0]  r;
        int           nb;
        int           off;
        wi  = a[63:3];
        wn  = wi + 61'd1;
        cat = {tb_mem[wn[3:0]], tb_mem[wi[3:0]]};
        r   = '0;
        nb  = 1 << sz;
        off = int'(a[2:0]);
        for (int i = 0; i < nb; i++) r[8*i +: 8] = cat[8*(off+i) +: 8];
        return r;
    endfunction

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic neg_at(input int c);
        goto(c);
        @(negedge clk);
    endtask

    task automatic preload(input int idx, input logic [63:0] v);
        pl_idx = 4'(idx);
        pl_val = v;
        pl_en  = 1'b1;
        @(posedge clk);
        #1;
        pl_en  = 1'b0;
    endtask

    task automatic drive_ls(input logic [63:0] a, input logic [1:0] s, input logic w, input logic [63:0] d);
        ls_addr = a; ls_size = s; ls_wen = w; ls_wdata = d; ls_req = 1'b1;
    endtask

    task automatic drive_if(input logic [63:0] a, input logic [1:0] s, input logic w, input logic [63:0] d);
        if_addr = a; if_size = s; if_wen = w; if_wdata = d; if_req = 1'b1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ctl"}, 64'({if_ack, ls_ack, mem_ren, mem_wen}), 64'h0);
        chk({tag, "_addr"}, mem_addr, 64'h0);
        chk({tag, "_wd_wm"}, mem_wdata | mem_wmask, 64'h0);
        chk({tag, "_rdata"}, if_rdata | ls_rdata, 64'h0);
    endtask

    int n;
    int lat;
    logic [63:0] ra;
    logic [1:0]  rs;
    logic        use_ls;

    initial begin
        // Reset with a request already pending: nothing may reach memory
        rst = 1'b1;
        drive_ls(RAM_BASE, SZ_8B, 1'b0, 64'h0);
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) preload(i, 64'h0);
        @(negedge clk);
        chk_idle("reset");
        goto(cyc + 1);
        rst = 1'b0;
        ls_req = 1'b0;

        // Simultaneous requests from reset, held: ls, if, ls
        preload(1, 64'h0A0A_1111_2222_3333);
        preload(2, 64'h0B0B_4444_5555_6666);
        n = cyc;
        drive_if(RAM_BASE + 64'd8,  SZ_8B, 1'b0, 64'h0);
        drive_ls(RAM_BASE + 64'd16, SZ_8B, 1'b0, 64'h0);
        exp_q.push_back('{1'b1, 64'h0B0B_4444_5555_6666, n + 2});
        exp_q.push_back('{1'b0, 64'h0A0A_1111_2222_3333, n + 5});
        exp_q.push_back('{1'b1, 64'h0B0B_4444_5555_6666, n + 8});
        neg_at(n + 1); chk("tie_first_ls_addr",  mem_addr, 64'h1000_0002);
        neg_at(n + 4); chk("tie_second_if_addr", mem_addr, 64'h1000_0001);
        neg_at(n + 7); chk("tie_third_ls_addr",  mem_addr, 64'h1000_0002);
        goto(n + 9);
        if_req = 1'b0; ls_req = 1'b0;
        neg_at(n + 10); chk("tie_quiet", 64'({mem_ren, mem_wen}), 64'h0);

        // Aligned 8-byte read
        preload(0, 64'h1122_3344_5566_7788);
        n = cyc;
        drive_ls(RAM_BASE, SZ_8B, 1'b0, 64'h0);
        exp_q.push_back('{1'b1, 64'h1122_3344_5566_7788, n + 2});
        neg_at(n + 1);
        chk("r8_ren", 64'(mem_ren), 64'h1);
        chk("r8_wen", 64'(mem_wen), 64'h0);
        chk("r8_addr", mem_addr, 64'h1000_0000);
        neg_at(n + 2); chk("r8_ren_once", 64'(mem_ren), 64'h0);
        goto(n + 3); ls_req = 1'b0;

        // Unaligned 4-byte read spanning two words
        preload(0, 64'h8877_6655_4433_2211);
        preload(1, 64'h0000_0000_0000_00AA);
        n = cyc;
        drive_ls(RAM_BASE + 64'd5, SZ_4B, 1'b0, 64'h0);
        exp_q.push_back('{1'b1, 64'h0000_0000_AA88_7766, n + 3});
        neg_at(n + 1); chk("r2b_b1_addr", mem_addr, 64'h1000_0000); chk("r2b_b1_ren", 64'(mem_ren), 64'h1);
        neg_at(n + 2); chk("r2b_b2_addr", mem_addr, 64'h1000_0001); chk("r2b_b2_ren", 64'(mem_ren), 64'h1);
        neg_at(n + 3); chk("r2b_resp_ren", 64'(mem_ren), 64'h0);
        goto(n + 4); ls_req = 1'b0;

        // Unaligned 4-byte write spanning two words, then read back
        n = cyc;
        drive_ls(RAM_BASE + 64'd6, SZ_4B, 1'b1, 64'hDEAD_BEEF);
        exp_q.push_back('{1'b1, 64'h0, n + 3});
        neg_at(n + 1);
        chk("w_b1_ctl",   64'({mem_wen, mem_ren}), 64'h2);
        chk("w_b1_addr",  mem_addr,  64'h1000_0000);
        chk("w_b1_wmask", mem_wmask, 64'hFFFF_0000_0000_0000);
        chk("w_b1_wdata", mem_wdata, 64'hBEEF_0000_0000_0000);
        neg_at(n + 2);
        chk("w_b2_ctl",   64'({mem_wen, mem_ren}), 64'h2);
        chk("w_b2_addr",  mem_addr,  64'h1000_0001);
        chk("w_b2_wmask", mem_wmask, 64'h0000_0000_0000_FFFF);
        chk("w_b2_wdata", mem_wdata, 64'h0000_0000_0000_DEAD);
        neg_at(n + 3); chk("w_resp_wen", 64'(mem_wen), 64'h0);
        goto(n + 4); ls_req = 1'b0; ls_wen = 1'b0;
        n = cyc;
        drive_ls(RAM_BASE + 64'd6, SZ_4B, 1'b0, 64'h0);
        exp_q.push_back('{1'b1, 64'hDEAD_BEEF, n + 3});
        goto(n + 4); ls_req = 1'b0;

        // if-side size/offset boundaries: 2B at 1, 1B at 7 (one beat), 2B at 7 (two beats)
        preload(1, 64'h0123_4567_89AB_CDEF);
        preload(2, 64'hFFEE_DDCC_BBAA_9988);
        n = cyc;
        drive_if(RAM_BASE + 64'd9, SZ_2B, 1'b0, 64'h0);
        exp_q.push_back('{1'b0, 64'hABCD, n + 2});
        neg_at(n + 2); chk("if_h_single_beat", 64'(mem_ren), 64'h0);
        goto(n + 3); if_req = 1'b0;
        n = cyc;
        drive_if(RAM_BASE + 64'd15, SZ_1B, 1'b0, 64'h0);
        exp_q.push_back('{1'b0, 64'h01, n + 2});
        neg_at(n + 2); chk("if_b7_single_beat", 64'(mem_ren), 64'h0);
        goto(n + 3); if_req = 1'b0;
        n = cyc;
        drive_if(RAM_BASE + 64'd15, SZ_2B, 1'b0, 64'h0);
        exp_q.push_back('{1'b0, 64'h8801, n + 3});
        goto(n + 4); if_req = 1'b0;

        // Word index wraps at the top of the address space
        n = cyc;
        drive_ls(64'hFFFF_FFFF_FFFF_FFFC, SZ_8B, 1'b1, 64'h1122_3344_5566_7788);
        exp_q.push_back('{1'b1, 64'h0, n + 3});
        neg_at(n + 1);
        chk("wrap_b1_addr",  mem_addr,  64'h1FFF_FFFF_FFFF_FFFF);
        chk("wrap_b1_wmask", mem_wmask, 64'hFFFF_FFFF_0000_0000);
        chk("wrap_b1_wdata", mem_wdata, 64'h5566_7788_0000_0000);
        neg_at(n + 2);
        chk("wrap_b2_addr",  mem_addr,  64'h0);
        chk("wrap_b2_wmask", mem_wmask, 64'h0000_0000_FFFF_FFFF);
        chk("wrap_b2_wdata", mem_wdata, 64'h0000_0000_1122_3344);
        goto(n + 4); ls_req = 1'b0; ls_wen = 1'b0;

        // if pulses for one cycle while ls owns the memory: withdrawn
        n = cyc;
        drive_ls(RAM_BASE + 64'd5, SZ_4B, 1'b0, 64'h0);
        exp_q.push_back('{1'b1, model_read(RAM_BASE + 64'd5, SZ_4B), n + 3});
        goto(n + 1);
        drive_if(RAM_BASE + 64'd8, SZ_8B, 1'b0, 64'h0);
        goto(n + 2);
        if_req = 1'b0;
        neg_at(n + 2); chk("pulse_b2_addr_ls", mem_addr, 64'h1000_0001);
        goto(n + 4); ls_req = 1'b0;
        neg_at(n + 5); chk("pulse_no_if_traffic", 64'({mem_ren, mem_wen}), 64'h0);
        goto(n + 9);

        // Reset during the first beat of a two-beat write
        preload(1, 64'h0);
        preload(2, 64'h0);
        n = cyc;
        drive_ls(RAM_BASE + 64'd14, SZ_4B, 1'b1, 64'hCAFE_F00D);
        goto(n + 1);
        rst = 1'b1;
        neg_at(n + 1);
        chk("rstmid_wen", 64'(mem_wen), 64'h0);
        chk("rstmid_wmask", mem_wmask, 64'h0);
        goto(n + 2);
        rst = 1'b0; ls_req = 1'b0; ls_wen = 1'b0;
        neg_at(n + 2); chk_idle("rstmid_after");
        neg_at(n + 3); chk_idle("rstmid_after2");
        chk("rstmid_mem1", tb_mem[1], 64'h0);
        chk("rstmid_mem2", tb_mem[2], 64'h0);
        preload(1, 64'h5555_AAAA_0F0F_F0F0);
        n = cyc;
        drive_ls(RAM_BASE + 64'd8, SZ_8B, 1'b0, 64'h0);
        exp_q.push_back('{1'b1, 64'h5555_AAAA_0F0F_F0F0, n + 2});
        goto(n + 3); ls_req = 1'b0;

        // Random reads from both sides against the byte model
        for (int i = 0; i < 10; i++) preload(i, {$urandom, $urandom});
        for (int k = 0; k < 8; k++) begin
            ra     = RAM_BASE + 64'($urandom_range(0, 63));
            rs     = 2'($urandom_range(0, 3));
            lat    = (({1'b0, ra[2:0]} + (4'd1 << rs)) > 4'd8) ? 3 : 2;
            use_ls = (k % 2) == 0;
            n = cyc;
            if (use_ls) drive_ls(ra, rs, 1'b0, 64'h0);
            else        drive_if(ra, rs, 1'b0, 64'h0);
            exp_q.push_back('{use_ls, model_read(ra, rs), n + lat});
            goto(n + lat + 1);
            if_req = 1'b0; ls_req = 1'b0;
        end

        goto(cyc + 4);
        chk("sb_drain", 64'(exp_q.size()), 64'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
